fifo_wr_arbiter: RTL

Write-side arbiter that shares one synchronous FIFO between NUM_REQ independent producers. It accepts valid/ready transfers from each requester and grants them with a round-robin policy and bounded bursts. It drives the FIFO write port from registers and throttles itself from the FIFO flags so the FIFO never overflows. It also checks FIFO write acknowledges and overflow, and latches sticky error flags.

---
 rtl/fifo_arb_pkg.sv | 6 +
 rtl/fifo_rr_picker.sv | 22 ++
 rtl/fifo_wr_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and default sizing for the FIFO write arbiter
package fifo_arb_pkg;
    typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_e;
    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_MAX_BURST = 4;
endpackage

// File: rtl/fifo_rr_picker.sv
// fifo_rr_picker: first valid requester at or above rr_ptr, wrapping modulo NUM_REQ
module fifo_rr_picker #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    output logic [$clog2(NUM_REQ)-1:0] winner,
    output logic                       any_valid
);
    localparam int IW = $clog2(NUM_REQ);
    logic [IW-1:0] idx;
    assign any_valid = |req;
    // Walk from the farthest slot down so the nearest valid slot is written last.
    always_comb begin
        winner = '0;
        idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = IW'((int'(rr_ptr) + k) % NUM_REQ);
            if (req[idx]) winner = idx;
        end
    end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-bounded arbiter feeding one shared FIFO write port,
// throttled by the FIFO flags and checking write acks and overflow.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int MAX_BURST  = DEF_MAX_BURST
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_wr_en,
    output logic [FIFO_WIDTH-1:0]         fifo_data_in,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    input  logic                          fifo_full,
    input  logic                          fifo_almostfull,
    input  logic                          fifo_wr_ack,
    input  logic                          fifo_overflow,
    output logic                          err_ack,
    output logic                          err_overflow
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

    if (NUM_REQ < 2 || MAX_BURST < 1 || FIFO_DEPTH < 1) begin : g_bad_params
        $error("fifo_wr_arbiter: illegal parameter set");
    end

    arb_state_e            state_q, state_d;
    logic [IW-1:0]         owner_q, owner_d, rr_ptr_q, rr_ptr_d;
    logic [BW-1:0]         burst_cnt_q, burst_cnt_d;
    logic                  fifo_wr_en_q, fifo_wr_en_d;
    logic [FIFO_WIDTH-1:0] fifo_data_in_q, fifo_data_in_d, sel_data;
    logic [IW-1:0]         grant_id_q, grant_id_d, src, winner;
    logic                  err_ack_q, err_ack_d, err_overflow_q, err_overflow_d;
    logic                  wr_en_dly_q, chk_en_q;
    logic                  any_valid, allow, accept;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        return (i == IW'(NUM_REQ - 1)) ? '0 : i + 1'b1;
    endfunction

    fifo_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req       (req_valid),
        .rr_ptr    (rr_ptr_q),
        .winner    (winner),
        .any_valid (any_valid)
    );

    // A pending registered write counts against the last free slot.
    assign allow = !fifo_full && !(fifo_almostfull && fifo_wr_en_q);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        burst_cnt_d = burst_cnt_q;
        rr_ptr_d = rr_ptr_q;
        req_ready = '0;
        accept = 1'b0;
        src = winner;
        if (state_q == ARB_IDLE) begin
            if (any_valid && allow) begin
                req_ready[winner] = 1'b1;
                accept = 1'b1;
                owner_d = winner;
                burst_cnt_d = BW'(1);
                if (MAX_BURST > 1) state_d = ARB_BURST;
                else rr_ptr_d = next_idx(winner);
            end
        end else begin
            src = owner_q;
            if (!req_valid[owner_q]) begin
                state_d = ARB_IDLE;
                rr_ptr_d = next_idx(owner_q);
            end else if (allow) begin
                req_ready[owner_q] = 1'b1;
                accept = 1'b1;
                burst_cnt_d = burst_cnt_q + 1'b1;
                if (burst_cnt_d == BURST_MAX) begin
                    state_d = ARB_IDLE;
                    rr_ptr_d = next_idx(owner_q);
                end
            end
        end
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (src == IW'(i)) sel_data = req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
        fifo_wr_en_d = accept;
        fifo_data_in_d = accept ? sel_data : fifo_data_in_q;
        grant_id_d = accept ? src : grant_id_q;
        err_ack_d = err_ack_q | (chk_en_q & (fifo_wr_ack ^ wr_en_dly_q));
        err_overflow_d = err_overflow_q | fifo_overflow;
    end

    // chk_en_q masks the ack of a write that was in flight when reset hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ARB_IDLE;
            owner_q        <= '0;
            burst_cnt_q    <= '0;
            rr_ptr_q       <= '0;
            fifo_wr_en_q   <= 1'b0;
            fifo_data_in_q <= '0;
            grant_id_q     <= '0;
            err_ack_q      <= 1'b0;
            err_overflow_q <= 1'b0;
            wr_en_dly_q    <= 1'b0;
            chk_en_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            burst_cnt_q    <= burst_cnt_d;
            rr_ptr_q       <= rr_ptr_d;
            fifo_wr_en_q   <= fifo_wr_en_d;
            fifo_data_in_q <= fifo_data_in_d;
            grant_id_q     <= grant_id_d;
            err_ack_q      <= err_ack_d;
            err_overflow_q <= err_overflow_d;
            wr_en_dly_q    <= fifo_wr_en_q;
            chk_en_q       <= 1'b1;
        end
    end

    assign fifo_wr_en   = fifo_wr_en_q;
    assign fifo_data_in = fifo_data_in_q;
    assign grant_id     = grant_id_q;
    assign err_ack      = err_ack_q;
    assign err_overflow = err_overflow_q;
endmodule
